// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences one instruction
// through fetch/decode/execute/memory/writeback with a MemReady timeout.
module multicycle_control #(
   parameter int TIMEOUT = 255
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [5:0] Opcode,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       Retire,
   output logic       Illegal,
   output logic       MemErr,
   output logic [3:0] State
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
   } state_t;

   typedef enum logic [2:0] {
      C_RTYPE, C_LW, C_SW, C_BEQ, C_J, C_ADDI
   } cls_t;

   state_t        state_q, state_d;
   cls_t          cls_q, cls_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q;
   logic          retire_q, retire_d, illegal_q, illegal_d, memerr_q, memerr_d;
   logic          to_hit, is_mem, en;

   logic       pcwrite_c, iord_c, memread_c, memwrite_c, irwrite_c;
   logic       memtoreg_c, regdst_c, regwrite_c, alusrca_c;
   logic [1:0] alusrcb_c, aluop_c, pcsource_c;

   // Timeout fires on the cycle the wait count would reach TIMEOUT with no completion
   assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST) && !MemReady;

   always_comb begin
      state_d    = state_q;
      cls_d      = cls_q;
      cnt_d      = cnt_q;
      retire_d   = 1'b0;
      illegal_d  = 1'b0;
      memerr_d   = 1'b0;
      is_mem     = 1'b0;
      pcwrite_c  = 1'b0;
      iord_c     = 1'b0;
      memread_c  = 1'b0;
      memwrite_c = 1'b0;
      irwrite_c  = 1'b0;
      memtoreg_c = 1'b0;
      regdst_c   = 1'b0;
      regwrite_c = 1'b0;
      alusrca_c  = 1'b0;
      alusrcb_c  = 2'b00;
      aluop_c    = 2'b00;
      pcsource_c = 2'b00;
      case (state_q)
         S_FETCH: begin
            is_mem    = 1'b1;
            memread_c = 1'b1;
            alusrcb_c = 2'b01;
            if (MemReady) begin
               irwrite_c = 1'b1;
               pcwrite_c = 1'b1;
               state_d   = S_DECODE;
            end else if (to_hit) begin
               memerr_d = 1'b1;
            end
         end
         S_DECODE: begin
            alusrcb_c = 2'b11;
            case (Opcode)
               6'b000000: begin cls_d = C_RTYPE; state_d = S_EXEC;   end
               6'b100011: begin cls_d = C_LW;    state_d = S_MEMADR; end
               6'b101011: begin cls_d = C_SW;    state_d = S_MEMADR; end
               6'b000100: begin cls_d = C_BEQ;   state_d = S_BRANCH; end
               6'b000010: begin cls_d = C_J;     state_d = S_JUMP;   end
               6'b001000: begin cls_d = C_ADDI;  state_d = S_ADDIEX; end
               default:   begin illegal_d = 1'b1; state_d = S_FETCH; end
            endcase
         end
         S_MEMADR: begin
            alusrca_c = 1'b1;
            alusrcb_c = 2'b10;
            state_d   = (cls_q == C_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            is_mem    = 1'b1;
            memread_c = 1'b1;
            iord_c    = 1'b1;
            if (MemReady) begin
               state_d = S_MEMWB;
            end else if (to_hit) begin
               memerr_d = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_MEMWB: begin
            regwrite_c = 1'b1;
            memtoreg_c = 1'b1;
            retire_d   = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            is_mem     = 1'b1;
            memwrite_c = 1'b1;
            iord_c     = 1'b1;
            if (MemReady) begin
               retire_d = 1'b1;
               state_d  = S_FETCH;
            end else if (to_hit) begin
               memerr_d = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_EXEC: begin
            alusrca_c = 1'b1;
            aluop_c   = 2'b10;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            regdst_c   = 1'b1;
            regwrite_c = 1'b1;
            retire_d   = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alusrca_c  = 1'b1;
            aluop_c    = 2'b01;
            pcsource_c = 2'b01;
            pcwrite_c  = Zero;
            retire_d   = 1'b1;
            state_d    = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca_c = 1'b1;
            alusrcb_c = 2'b10;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite_c = 1'b1;
            retire_d   = 1'b1;
            state_d    = S_FETCH;
         end
         S_JUMP: begin
            pcsource_c = 2'b10;
            pcwrite_c  = 1'b1;
            retire_d   = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      // Wait counter restarts whenever a memory state is (re)entered or abandoned
      if (!is_mem || state_d != state_q || memerr_d) begin
         cnt_d = '0;
      end else if (!MemReady) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // run_q holds the FSM and outputs quiet until the first edge after reset release
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= S_FETCH;
         cls_q     <= C_RTYPE;
         cnt_q     <= '0;
         run_q     <= 1'b0;
         retire_q  <= 1'b0;
         illegal_q <= 1'b0;
         memerr_q  <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (run_q) begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cnt_q     <= cnt_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            memerr_q  <= memerr_d;
         end
      end
   end

   assign en       = Rst_n & run_q;
   assign PCWrite  = en & pcwrite_c;
   assign IorD     = en & iord_c;
   assign MemRead  = en & memread_c;
   assign MemWrite = en & memwrite_c;
   assign IRWrite  = en & irwrite_c;
   assign MemtoReg = en & memtoreg_c;
   assign RegDst   = en & regdst_c;
   assign RegWrite = en & regwrite_c;
   assign ALUSrcA  = en & alusrca_c;
   assign ALUSrcB  = en ? alusrcb_c : 2'b00;
   assign ALUOp    = en ? aluop_c : 2'b00;
   assign PCSource = en ? pcsource_c : 2'b00;
   assign Retire   = en & retire_q;
   assign Illegal  = en & illegal_q;
   assign MemErr   = en & memerr_q;
   assign State    = Rst_n ? state_q : 4'd0;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences one instruction at a time through fetch/decode/execute/memory/writeback.
- Drives datapath mux selects, register/memory enables and the 2-bit ALUOp consumed by the ALU control decoder.
- Waits on a memory ready handshake and aborts a memory access that stalls past a timeout.

Parameters:
TIMEOUT, 255, max cycles to wait for MemReady in a memory state; 0 disables the timeout. Counter width is $clog2(TIMEOUT+1), minimum 1.

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Opcode  in  6  instruction[31:26] from instruction register
Zero  in  1  ALU zero flag
MemReady  in  1  memory access complete this cycle
PCWrite  out  1  PC load enable (includes branch condition)
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  writeback data: 0=ALUOut, 1=MDR
RegDst  out  1  dest register: 0=rt, 1=rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
ALUOp  out  2  00=add, 01=sub, 10=funct-decoded
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
Retire  out  1  1-cycle pulse: instruction completed
Illegal  out  1  1-cycle pulse: unsupported opcode
MemErr  out  1  1-cycle pulse: MemReady timeout
State  out  4  current state code, for debug

Behaviour:
- Reset: State=FETCH(0), timeout counter=0, latched opcode class=R-type. All outputs are 0 while Rst_n=0 (gated combinationally). FETCH outputs resume on the first edge after release.
- Outputs are Moore, decoded from the registered state. Exceptions:
  - PCWrite/IRWrite in FETCH depend on MemReady.
  - PCWrite in BRANCH depends on Zero.
  - Pulse outputs are registered with the transition that causes them.
- Unlisted outputs are 0 in every state.
- Opcode class is latched in DECODE. Later states use the latch, not live Opcode.
- States (code: outputs -> next):
  - 0 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. If MemReady: IRWrite=1, PCWrite=1 -> DECODE; else stay.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
    - 000000 -> EXEC
    - 100011/101011 -> MEMADR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDIEX
    - other -> FETCH with Illegal=1
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD; sw -> MEMWR.
  - 3 MEMRD: MemRead=1, IorD=1. MemReady -> MEMWB.
  - 4 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH, Retire=1.
  - 5 MEMWR: MemWrite=1, IorD=1. MemReady -> FETCH, Retire=1.
  - 6 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - 7 ALUWB: RegDst=1, RegWrite=1 -> FETCH, Retire=1.
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWrite=Zero -> FETCH, Retire=1.
  - 9 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - 10 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH, Retire=1.
  - 11 JUMP: PCSource=10, PCWrite=1 -> FETCH, Retire=1.
  - 12-15: unreachable; recover to FETCH next cycle with no pulse.
- Timeout (FETCH, MEMRD, MEMWR):
  - Counter clears on entry to a memory state and increments each cycle MemReady=0.
  - If TIMEOUT!=0 and the count reaches TIMEOUT with MemReady still 0: MemErr=1 -> FETCH. No Retire, no IRWrite/PCWrite.
  - MemReady=1 on the same cycle the count hits TIMEOUT: completion wins, no MemErr.
  - MemReady held high: FETCH completes in 1 cycle.
- Cycle counts with zero wait states:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
- Reset mid-instruction: state returns to FETCH immediately; no Retire; outputs 0 during reset.

Test Plan:
- Reset then MemReady=1 constant, Opcode=000000 -> states 0,1,6,7,0. ALUOp=10 in EXEC; RegWrite=RegDst=1 in ALUWB; Retire pulse on cycle 4.
- lw (100011), MemReady=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles with MemRead=IorD=1. Then MEMWB with MemtoReg=1, RegWrite=1; Retire once.
- beq (000100): Zero=1 -> PCWrite=1, PCSource=01, ALUOp=01 in BRANCH. Zero=0 -> PCWrite=0. Both return to FETCH.
- Opcode=111111 -> DECODE -> FETCH with Illegal=1 for 1 cycle; no Retire; RegWrite/MemWrite never asserted.
- TIMEOUT=4, sw with MemReady stuck 0 -> MEMWR lasts 4 cycles; MemErr=1; FETCH next; no Retire. Repeat with MemReady=1 on the 4th cycle -> Retire, no MemErr.
- Assert Rst_n=0 during MEMRD -> all outputs 0 immediately, State=0; after release FETCH outputs (MemRead=1, ALUSrcB=01).
